// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: access-type codes,
// datapath widths, FSM state encoding and request legality helpers.
package dmem_ctrl_pkg;

  // Datapath widths
  localparam int MEM_W      = 32;  // data word width
  localparam int MEM_ADDR_W = 32;  // pipeline byte-address width
  localparam int REG_ADDR_W = 5;   // register-file index width

  // Load access types (funct3)
  localparam logic [2:0] INST_LB  = 3'b000;
  localparam logic [2:0] INST_LH  = 3'b001;
  localparam logic [2:0] INST_LW  = 3'b010;
  localparam logic [2:0] INST_LBU = 3'b100;
  localparam logic [2:0] INST_LHU = 3'b101;

  // Store access types (funct3)
  localparam logic [2:0] INST_SB  = 3'b000;
  localparam logic [2:0] INST_SH  = 3'b001;
  localparam logic [2:0] INST_SW  = 3'b010;

  // Controller states
  typedef enum logic [2:0] {
    DMEM_IDLE = 3'd0,
    DMEM_RD   = 3'd1,
    DMEM_LD   = 3'd2,
    DMEM_MRG  = 3'd3,
    DMEM_WR   = 3'd4,
    DMEM_ERR  = 3'd5
  } dmem_state_t;

  // funct3 codes that do not name a load (or a store) at all
  function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
    if (we) begin
      return !((funct3 == INST_SB) || (funct3 == INST_SH) || (funct3 == INST_SW));
    end
    return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
  endfunction

  // Halfword accesses need addr[0] = 0, word accesses need addr[1:0] = 0.
  // funct3[1:0] is 01 for LH/LHU/SH and 10 for LW/SW; the remaining codes
  // that share those low bits are illegal and rejected separately.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // A request that must complete with an error response and no RAM access
  function automatic logic access_fault(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    return is_illegal(we, funct3) || is_misaligned(funct3, addr_lo);
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath of the data-memory controller: extracts and extends
// load data from a RAM word, and merges partial store data into an old word.
// Purely combinational.
module dmem_lane_unit
  import dmem_ctrl_pkg::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       addr_lo,
  input  logic [MEM_W-1:0] rdata,
  input  logic [MEM_W-1:0] wdata,
  output logic [MEM_W-1:0] load_data,
  output logic [MEM_W-1:0] merge_data
);

  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Pick the addressed byte and halfword out of the read word
  always_comb begin
    load_byte = rdata[7:0];
    case (addr_lo)
      2'd0:    load_byte = rdata[7:0];
      2'd1:    load_byte = rdata[15:8];
      2'd2:    load_byte = rdata[23:16];
      default: load_byte = rdata[31:24];
    endcase
    load_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign- or zero-extend the selected lane according to the access type
  always_comb begin
    load_data = '0;
    case (funct3)
      INST_LB:  load_data = {{24{load_byte[7]}}, load_byte};
      INST_LH:  load_data = {{16{load_half[15]}}, load_half};
      INST_LW:  load_data = rdata;
      INST_LBU: load_data = {24'd0, load_byte};
      INST_LHU: load_data = {16'd0, load_half};
      default:  load_data = '0;
    endcase
  end

  // Store merge, one byte lane at a time: a lane takes store data when the
  // access covers it, otherwise it keeps the old RAM byte. Store data is
  // right-aligned, so SB feeds wdata[7:0] to every lane and SH feeds the
  // low halfword to both halves of the word.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);

    logic       lane_wr;
    logic [7:0] lane_src;

    assign lane_wr = (funct3 == INST_SW)
                  || ((funct3 == INST_SB) && (addr_lo == LANE))
                  || ((funct3 == INST_SH) && (addr_lo[1] == LANE[1]));

    assign lane_src = (funct3 == INST_SB) ? wdata[7:0]
                    : (funct3 == INST_SH) ? (LANE[0] ? wdata[15:8] : wdata[7:0])
                    : wdata[8*gi +: 8];

    assign merge_data[8*gi +: 8] = lane_wr ? lane_src : rdata[8*gi +: 8];
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller. Accepts one load/store request at a time,
// drives a single-port synchronous word RAM, runs partial stores as
// read-modify-write and returns lane-selected, extended load data.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  // request from the memory stage
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [2:0]            req_funct3_i,
  input  logic [MEM_ADDR_W-1:0] req_addr_i,
  input  logic [MEM_W-1:0]      req_wdata_i,
  input  logic [REG_ADDR_W-1:0] req_rd_i,
  // completion
  output logic                  rsp_valid_o,
  output logic [MEM_W-1:0]      rsp_data_o,
  output logic [REG_ADDR_W-1:0] rsp_rd_o,
  output logic                  rsp_reg_w_o,
  output logic                  rsp_err_o,
  // RAM port
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [MEM_W-1:0]      ram_wdata_o,
  input  logic [MEM_W-1:0]      ram_rdata_i
);

  dmem_state_t           state_reg;
  logic                  we_reg;
  logic [2:0]            funct3_reg;
  logic [ADDR_W+1:0]     addr_reg;
  logic [MEM_W-1:0]      wdata_reg;
  logic [REG_ADDR_W-1:0] rd_reg;

  logic [MEM_W-1:0]      load_data;
  logic [MEM_W-1:0]      merge_data;
  logic [ADDR_W-1:0]     word_addr;

  // Byte-address bits above the RAM size are dropped so accesses wrap
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[MEM_ADDR_W-1:ADDR_W+2];

  assign word_addr   = addr_reg[ADDR_W+1:2];
  assign req_ready_o = (state_reg == DMEM_IDLE);

  dmem_lane_unit u_lane (
    .funct3     (funct3_reg),
    .addr_lo    (addr_reg[1:0]),
    .rdata      (ram_rdata_i),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Request latch and state sequencing; the request is captured only on
  // handshake, so input changes while busy have no effect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= DMEM_IDLE;
      we_reg     <= 1'b0;
      funct3_reg <= 3'd0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rd_reg     <= '0;
    end else begin
      case (state_reg)
        DMEM_IDLE: begin
          if (req_valid_i) begin
            we_reg     <= req_we_i;
            funct3_reg <= req_funct3_i;
            addr_reg   <= req_addr_i[ADDR_W+1:0];
            wdata_reg  <= req_wdata_i;
            rd_reg     <= req_rd_i;
            if (access_fault(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
              state_reg <= DMEM_ERR;
            end else if (req_we_i && (req_funct3_i == INST_SW)) begin
              state_reg <= DMEM_WR;
            end else begin
              state_reg <= DMEM_RD;
            end
          end
        end
        DMEM_RD:  state_reg <= we_reg ? DMEM_MRG : DMEM_LD;
        DMEM_LD,
        DMEM_MRG,
        DMEM_WR,
        DMEM_ERR: state_reg <= DMEM_IDLE;
        default:  state_reg <= DMEM_IDLE;
      endcase
    end
  end

  // RAM and response drive, decoded from the state register. Reset gates
  // everything so an interrupted read-modify-write never reaches the RAM,
  // and all response fields stay 0 outside the one-cycle response pulse.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_rd_o    = '0;
    rsp_reg_w_o = 1'b0;
    rsp_err_o   = 1'b0;
    if (!rst) begin
      case (state_reg)
        DMEM_RD: begin
          ram_en_o   = 1'b1;
          ram_addr_o = word_addr;
        end
        DMEM_LD: begin
          rsp_valid_o = 1'b1;
          rsp_reg_w_o = 1'b1;
          rsp_data_o  = load_data;
          rsp_rd_o    = rd_reg;
        end
        DMEM_MRG: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = word_addr;
          ram_wdata_o = merge_data;
          rsp_valid_o = 1'b1;
        end
        DMEM_WR: begin
          ram_en_o    = 1'b1;
          ram_we_o    = 1'b1;
          ram_addr_o  = word_addr;
          ram_wdata_o = wdata_reg;
          rsp_valid_o = 1'b1;
        end
        DMEM_ERR: begin
          rsp_valid_o = 1'b1;
          rsp_err_o   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural synchronous RAM and a
// response scoreboard.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int ADDR_W = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'd0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic        rsp_reg_w_o;
  logic        rsp_err_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i = '0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .req_rd_i     (req_rd_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_rd_o     (rsp_rd_o),
    .rsp_reg_w_o  (rsp_reg_w_o),
    .rsp_err_o    (rsp_err_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i)
  );

  // Behavioural RAM with one-cycle read latency plus an access log
  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic              preload_done = 1'b0;
  int                cyc = 0;
  int                rd_cnt = 0;
  int                wr_cnt = 0;
  int                last_rd_cyc = 0;
  int                last_wr_cyc = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [31:0]       last_wr_data = '0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!preload_done) begin
      mem[12'h040] = 32'h8899_AABB;
      preload_done = 1'b1;
    end
    if (ram_en_o) begin
      if (ram_we_o) begin
        mem[ram_addr_o] = ram_wdata_o;
        wr_cnt       = wr_cnt + 1;
        last_wr_cyc  = cyc;
        last_wr_addr = ram_addr_o;
        last_wr_data = ram_wdata_o;
      end else begin
        ram_rdata_i  <= mem[ram_addr_o];
        rd_cnt       = rd_cnt + 1;
        last_rd_cyc  = cyc;
        last_rd_addr = ram_addr_o;
      end
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        reg_w;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp)
    else begin
      n_err = n_err + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for its response and score it
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] e_data, input logic e_load, input logic e_err,
                        input int e_lat, output int acc, output int rd_base, output int wr_base);
    exp_t e;
    logic got;
    int   k;
    e.data  = e_data;
    e.rd    = e_load ? rd : 5'd0;
    e.reg_w = e_load;
    e.err   = e_err;
    e.lat   = 8'(e_lat);
    sb_q.push_back(e);

    @(negedge clk);
    chk("ready_idle", 32'(req_ready_o), 32'd1);
    rd_base      = rd_cnt;
    wr_base      = wr_cnt;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    req_rd_i     = rd;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    acc          = cyc;
    req_valid_i  = 1'b0;
    // scramble the request bus; a busy controller must ignore it
    req_we_i     = ~we;
    req_funct3_i = 3'b111;
    req_addr_i   = 32'hFFFF_FFFF;
    req_wdata_i  = 32'h0BAD_F00D;
    req_rd_i     = 5'h1F;

    got = 1'b0;
    k   = 0;
    while (!got && k < 8) begin
      @(negedge clk);
      k = k + 1;
      if (rsp_valid_o === 1'b1) got = 1'b1;
    end
    chk("rsp_seen", 32'(got), 32'd1);
    e = '0;
    if (sb_q.size() > 0) e = sb_q.pop_front();
    if (got) begin
      chk("latency", 32'(k), 32'(e.lat));
      chk("rsp_data", rsp_data_o, e.data);
      chk("rsp_rd", 32'(rsp_rd_o), 32'(e.rd));
      chk("rsp_reg_w", 32'(rsp_reg_w_o), 32'(e.reg_w));
      chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
    end
    $display("txn we=%0b f3=%03b addr=%h wdata=%h rd=%0d -> data=%h rd=%0d reg_w=%0b err=%0b lat=%0d",
             we, f3, addr, wdata, rd, rsp_data_o, rsp_rd_o, rsp_reg_w_o, rsp_err_o, k);
    @(negedge clk);
    chk("pulse_end", 32'(rsp_valid_o), 32'd0);
    chk("rsp_data_idle", rsp_data_o, 32'd0);
    chk("ready_after", 32'(req_ready_o), 32'd1);
  endtask

  int acc, rb, wb;

  initial begin
    // reset
    repeat (3) @(negedge clk);
    chk("rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_ram_we", 32'(ram_we_o), 32'd0);
    chk("reset_rsp_data", rsp_data_o, 32'd0);

    // loads from the preloaded word 0x40 = 0x8899AABB
    do_req(1'b0, INST_LB, 32'h103, 32'd0, 5'd5, 32'hFFFF_FF88, 1'b1, 1'b0, 2, acc, rb, wb);
    chk("lb_reads", 32'(rd_cnt - rb), 32'd1);
    chk("lb_rd_addr", 32'(last_rd_addr), 32'h40);
    chk("lb_rd_cyc", 32'(last_rd_cyc - acc), 32'd1);
    chk("lb_writes", 32'(wr_cnt - wb), 32'd0);
    do_req(1'b0, INST_LHU, 32'h102, 32'd0, 5'd7, 32'h0000_8899, 1'b1, 1'b0, 2, acc, rb, wb);
    do_req(1'b0, INST_LBU, 32'h100, 32'd0, 5'd9, 32'h0000_00BB, 1'b1, 1'b0, 2, acc, rb, wb);
    do_req(1'b0, INST_LH, 32'h102, 32'd0, 5'd3, 32'hFFFF_8899, 1'b1, 1'b0, 2, acc, rb, wb);
    do_req(1'b0, INST_LB, 32'h101, 32'd0, 5'd4, 32'hFFFF_FFAA, 1'b1, 1'b0, 2, acc, rb, wb);

    // reset during the merge cycle of an SH read-modify-write
    @(negedge clk);
    wb           = wr_cnt;
    req_we_i     = 1'b1;
    req_funct3_i = INST_SH;
    req_addr_i   = 32'h100;
    req_wdata_i  = 32'h0000_5555;
    req_rd_i     = 5'd0;
    req_valid_i  = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rmw_read_en", 32'(ram_en_o), 32'd1);
    @(negedge clk);
    chk("rmw_merge_we", 32'(ram_we_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("rmw_rst_ram_en", 32'(ram_en_o), 32'd0);
    chk("rmw_rst_ram_we", 32'(ram_we_o), 32'd0);
    chk("rmw_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("rmw_rst_ready", 32'(req_ready_o), 32'd1);
    chk("rmw_rst_no_write", 32'(wr_cnt - wb), 32'd0);
    $display("txn SH 0x100 abandoned by reset, writes=%0d", wr_cnt - wb);
    do_req(1'b0, INST_LW, 32'h100, 32'd0, 5'd1, 32'h8899_AABB, 1'b1, 1'b0, 2, acc, rb, wb);

    // partial stores: read at N+1, merged write at N+2
    do_req(1'b1, INST_SB, 32'h101, 32'h1234_5678, 5'd6, 32'd0, 1'b0, 1'b0, 2, acc, rb, wb);
    chk("sb_reads", 32'(rd_cnt - rb), 32'd1);
    chk("sb_rd_cyc", 32'(last_rd_cyc - acc), 32'd1);
    chk("sb_writes", 32'(wr_cnt - wb), 32'd1);
    chk("sb_wr_cyc", 32'(last_wr_cyc - acc), 32'd2);
    chk("sb_wr_addr", 32'(last_wr_addr), 32'h40);
    chk("sb_wr_data", last_wr_data, 32'h8899_78BB);
    do_req(1'b1, INST_SH, 32'h102, 32'h0000_CAFE, 5'd0, 32'd0, 1'b0, 1'b0, 2, acc, rb, wb);
    chk("sh_wr_data", last_wr_data, 32'hCAFE_78BB);
    do_req(1'b0, INST_LW, 32'h100, 32'd0, 5'd2, 32'hCAFE_78BB, 1'b1, 1'b0, 2, acc, rb, wb);

    // full-word store with an address above the RAM size
    do_req(1'b1, INST_SW, 32'h4104, 32'hDEAD_BEEF, 5'd0, 32'd0, 1'b0, 1'b0, 1, acc, rb, wb);
    chk("sw_reads", 32'(rd_cnt - rb), 32'd0);
    chk("sw_writes", 32'(wr_cnt - wb), 32'd1);
    chk("sw_wr_cyc", 32'(last_wr_cyc - acc), 32'd1);
    chk("sw_wr_addr", 32'(last_wr_addr), 32'h041);
    chk("sw_wr_data", last_wr_data, 32'hDEAD_BEEF);
    do_req(1'b0, INST_LW, 32'h104, 32'd0, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, acc, rb, wb);

    // misaligned and illegal accesses: error at N+1, no RAM traffic
    do_req(1'b0, INST_LW, 32'h102, 32'd0, 5'd8, 32'd0, 1'b0, 1'b1, 1, acc, rb, wb);
    chk("lw_mis_ram", 32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd0);
    do_req(1'b1, INST_SH, 32'h103, 32'h0000_1111, 5'd0, 32'd0, 1'b0, 1'b1, 1, acc, rb, wb);
    chk("sh_mis_ram", 32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd0);
    do_req(1'b0, 3'b011, 32'h100, 32'd0, 5'd8, 32'd0, 1'b0, 1'b1, 1, acc, rb, wb);
    chk("ld_ill_ram", 32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd0);
    do_req(1'b1, 3'b100, 32'h100, 32'h0000_2222, 5'd0, 32'd0, 1'b0, 1'b1, 1, acc, rb, wb);
    chk("st_ill_ram", 32'((rd_cnt - rb) + (wr_cnt - wb)), 32'd0);

    // error left the word untouched
    do_req(1'b0, INST_LW, 32'h100, 32'd0, 5'd10, 32'hCAFE_78BB, 1'b1, 1'b0, 2, acc, rb, wb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
